// File: rtl/aes_sbox_pkg.sv
// Shared types, tower-field primitives and isomorphism constants for the
// composite-field AES inverse S-box.
//   GF(2^2)        : z^2 + z + 1
//   GF((2^2)^2)    : w^2 + w + phi,    phi    = z
//   GF((2^4)^2)    : v^2 + v + lambda, lambda = z*w (nibble 4'h8)
package aes_sbox_pkg;

    typedef logic [7:0]  byte_t;
    typedef byte_t [15:0] state_t;
    typedef logic [3:0]  nib_t;
    typedef logic [1:0]  gf4_t;
    // Column i holds the image of basis bit i
    typedef byte_t [7:0] mat_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_e;

    localparam byte_t INV_AFFINE_C = 8'h05;

    function automatic gf4_t gf4_mul(input gf4_t a, input gf4_t b);
        return {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]),
                (a[1] & b[1]) ^ (a[0] & b[0])};
    endfunction

    function automatic gf4_t gf4_sq(input gf4_t a);
        return {a[1], a[1] ^ a[0]};
    endfunction

    // Multiply by phi = z
    function automatic gf4_t gf4_scale(input gf4_t a);
        return {a[1] ^ a[0], a[1]};
    endfunction

    function automatic nib_t gf16_mul(input nib_t a, input nib_t b);
        gf4_t hh;
        hh = gf4_mul(a[3:2], b[3:2]);
        return {hh ^ gf4_mul(a[3:2], b[1:0]) ^ gf4_mul(a[1:0], b[3:2]),
                gf4_scale(hh) ^ gf4_mul(a[1:0], b[1:0])};
    endfunction

    function automatic nib_t gf16_sq(input nib_t a);
        gf4_t hs;
        hs = gf4_sq(a[3:2]);
        return {hs, gf4_scale(hs) ^ gf4_sq(a[1:0])};
    endfunction

    // Multiply by lambda = z*w
    function automatic nib_t gf16_scale_lambda(input nib_t a);
        return {gf4_scale(a[3:2] ^ a[1:0]), gf4_scale(gf4_scale(a[3:2]))};
    endfunction

    // Inverse in GF(2^4); zero maps to zero
    function automatic nib_t gf16_inv(input nib_t a);
        gf4_t d;
        gf4_t d_inv;
        d     = gf4_scale(gf4_sq(a[3:2])) ^ gf4_sq(a[1:0]) ^ gf4_mul(a[3:2], a[1:0]);
        d_inv = gf4_sq(d);
        return {gf4_mul(a[3:2], d_inv), gf4_mul(a[3:2] ^ a[1:0], d_inv)};
    endfunction

    function automatic byte_t cf_mul(input byte_t a, input byte_t b);
        nib_t hh;
        hh = gf16_mul(a[7:4], b[7:4]);
        return {hh ^ gf16_mul(a[7:4], b[3:0]) ^ gf16_mul(a[3:0], b[7:4]),
                gf16_scale_lambda(hh) ^ gf16_mul(a[3:0], b[3:0])};
    endfunction

    function automatic byte_t mat_apply(input mat_t m, input byte_t v);
        byte_t r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (v[i]) r = r ^ m[i];
        end
        return r;
    endfunction

    function automatic byte_t inv_affine(input byte_t b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ INV_AFFINE_C;
    endfunction

    // Find a root beta of the AES polynomial x^8+x^4+x^3+x+1 in the composite
    // field; AES basis x^i then maps to beta^i.
    function automatic mat_t build_map();
        mat_t  m;
        byte_t beta, b1, b2, b3, b4, b8;
        logic  found;
        m     = '0;
        beta  = '0;
        found = 1'b0;
        for (int unsigned c = 2; c < 256; c++) begin
            b1 = 8'(c);
            b2 = cf_mul(b1, b1);
            b3 = cf_mul(b2, b1);
            b4 = cf_mul(b2, b2);
            b8 = cf_mul(b4, b4);
            if (!found && ((b8 ^ b4 ^ b3 ^ b1 ^ 8'h01) == 8'h00)) begin
                found = 1'b1;
                beta  = b1;
            end
        end
        m[0] = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            m[i] = cf_mul(m[i-1], beta);
        end
        return m;
    endfunction

    function automatic mat_t build_inv_map(input mat_t fwd);
        mat_t  m;
        byte_t img;
        m = '0;
        for (int unsigned a = 0; a < 256; a++) begin
            img = mat_apply(fwd, 8'(a));
            for (int unsigned j = 0; j < 8; j++) begin
                if (img == (8'h01 << j)) m[j] = 8'(a);
            end
        end
        return m;
    endfunction

    localparam mat_t MAP_TO_CF   = build_map();
    localparam mat_t MAP_FROM_CF = build_inv_map(MAP_TO_CF);

endpackage

// File: rtl/inv_sbox_cf.sv
// Combinational single-byte AES inverse S-box using composite-field inversion.
module inv_sbox_cf
    import aes_sbox_pkg::*;
(
    input  logic [7:0] value,
    output logic [7:0] result
);

    byte_t pre;
    byte_t cf;
    byte_t cf_inv;
    nib_t  hi;
    nib_t  lo;
    nib_t  d;
    nib_t  d_inv;

    // Inverse affine, map into GF((2^4)^2), invert, map back
    always_comb begin
        pre    = inv_affine(value);
        cf     = mat_apply(MAP_TO_CF, pre);
        hi     = cf[7:4];
        lo     = cf[3:0];
        d      = gf16_scale_lambda(gf16_sq(hi)) ^ gf16_sq(lo) ^ gf16_mul(hi, lo);
        d_inv  = gf16_inv(d);
        cf_inv = {gf16_mul(hi, d_inv), gf16_mul(hi ^ lo, d_inv)};
        result = mat_apply(MAP_FROM_CF, cf_inv);
    end

endmodule

// File: rtl/inv_sub_bytes_serial.sv
// InvSubBytes engine: processes a 128-bit state LANES bytes per cycle
// through shared inverse S-boxes, with valid/ready on both sides.
module inv_sub_bytes_serial
    import aes_sbox_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int unsigned   CHUNKS = 16 / LANES;
    localparam int unsigned   CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CW-1:0] LAST   = CW'(CHUNKS - 1);

    if (16 % LANES != 0) begin : g_lanes_check
        $error("inv_sub_bytes_serial: LANES must divide 16");
    end

    fsm_e          state;
    fsm_e          state_next;
    logic [CW-1:0] chunk;
    state_t        data;
    state_t        data_next;
    byte_t         lane_in  [LANES];
    byte_t         lane_out [LANES];

    // Select the bytes of the current chunk for the S-box lanes
    always_comb begin
        lane_in = '{default: '0};
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_in[l] = data[4'(32'(chunk) * LANES + l)];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        inv_sbox_cf u_sbox (
            .value  (lane_in[g]),
            .result (lane_out[g])
        );
    end

    // Write substituted bytes back into their own positions
    always_comb begin
        data_next = data;
        for (int unsigned l = 0; l < LANES; l++) begin
            data_next[4'(32'(chunk) * LANES + l)] = lane_out[l];
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        out_state  = data;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (chunk == LAST) state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State, chunk counter and state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            chunk <= '0;
            data  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data  <= in_state;
                        chunk <= '0;
                    end
                end
                BUSY: begin
                    data  <= data_next;
                    chunk <= chunk + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_sub_bytes_serial.sv
// Directed bench for inv_sub_bytes_serial at LANES = 4, 1, 2, 8, 16.
`timescale 1ns/1ps
module tb_inv_sub_bytes_serial;

    localparam int NDUT = 5;
    // Expected latency (16/LANES) for instances 0..4 (LANES 4, 1, 2, 8, 16)
    localparam int EXP_LAT [NDUT] = '{4, 16, 8, 2, 1};

    localparam logic [7:0] INV_TAB [256] = '{
        8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
        8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
        8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
        8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
        8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
        8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
        8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
        8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
        8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
        8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
        8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
        8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
        8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
        8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
        8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
        8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
    };

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid  [NDUT];
    logic         in_ready  [NDUT];
    logic [127:0] in_state  [NDUT];
    logic         out_valid [NDUT];
    logic         out_ready [NDUT];
    logic [127:0] out_state [NDUT];
    logic         busy      [NDUT];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    inv_sub_bytes_serial #(.LANES(4)) u_dut_l4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_state(in_state[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_state(out_state[0]), .busy(busy[0]));
    inv_sub_bytes_serial #(.LANES(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_state(in_state[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_state(out_state[1]), .busy(busy[1]));
    inv_sub_bytes_serial #(.LANES(2)) u_dut_l2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_state(in_state[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_state(out_state[2]), .busy(busy[2]));
    inv_sub_bytes_serial #(.LANES(8)) u_dut_l8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_state(in_state[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
        .out_state(out_state[3]), .busy(busy[3]));
    inv_sub_bytes_serial #(.LANES(16)) u_dut_l16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[4]), .in_ready(in_ready[4]),
        .in_state(in_state[4]), .out_valid(out_valid[4]), .out_ready(out_ready[4]),
        .out_state(out_state[4]), .busy(busy[4]));

    function automatic logic [127:0] fill(input logic [7:0] b);
        return {16{b}};
    endfunction

    // Drive one state into instance k, wait for the result, accept it.
    task automatic run_state(input int k, input logic [127:0] st,
                             output logic [127:0] res, output int lat);
        int waited;
        waited = 0;
        while (!in_ready[k] && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        in_state[k] = st;
        in_valid[k] = 1'b1;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        lat = 0;
        while (!out_valid[k] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = out_state[k];
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < NDUT; k++) begin
            vectors++;
            if (in_ready[k] !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_in_ready[%0d]: got %b, want 1", k, in_ready[k]);
            end
            vectors++;
            if (out_valid[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_out_valid[%0d]: got %b, want 0", k, out_valid[k]);
            end
            vectors++;
            if (busy[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_busy[%0d]: got %b, want 0", k, busy[k]);
            end
            vectors++;
            if (out_state[k] !== 128'h0) begin
                miscompares++;
                $display("FAIL reset_out_state[%0d]: got %h, want 0", k, out_state[k]);
            end
        end
    endtask

    task automatic test_single_values();
        logic [7:0]   ins  [4] = '{8'h63, 8'h7c, 8'h16, 8'hed};
        logic [7:0]   outs [4] = '{8'h00, 8'h01, 8'hff, 8'h53};
        logic [127:0] res;
        int           lat;
        for (int i = 0; i < 4; i++) begin
            run_state(0, fill(ins[i]), res, lat);
            vectors++;
            if (res !== fill(outs[i])) begin
                miscompares++;
                $display("FAIL single_%h: got %h, want %h", ins[i], res, fill(outs[i]));
            end
        end
    endtask

    task automatic test_table(input int k);
        logic [127:0] st;
        logic [127:0] exp;
        logic [127:0] res;
        int           lat;
        for (int s = 0; s < 16; s++) begin
            for (int i = 0; i < 16; i++) begin
                st[8*i +: 8]  = 8'(16 * s + i);
                exp[8*i +: 8] = INV_TAB[16 * s + i];
            end
            run_state(k, st, res, lat);
            vectors++;
            if (res !== exp) begin
                miscompares++;
                $display("FAIL table[dut%0d,s%0d]: got %h, want %h", k, s, res, exp);
            end
            vectors++;
            if (lat !== EXP_LAT[k]) begin
                miscompares++;
                $display("FAIL latency[dut%0d,s%0d]: got %0d, want %0d", k, s, lat, EXP_LAT[k]);
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [127:0] st;
        logic [127:0] exp;
        int           lat;
        logic         bad;
        for (int i = 0; i < 16; i++) begin
            st[8*i +: 8]  = 8'(8'hf0 + i);
            exp[8*i +: 8] = INV_TAB[8'hf0 + i];
        end
        in_state[0] = st;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        lat = 0;
        while (!out_valid[0] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        vectors++;
        if (lat !== 4) begin
            miscompares++;
            $display("FAIL bp_latency: got %0d, want 4", lat);
        end
        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin
                in_state[0] = fill(8'h63);
                in_valid[0] = 1'b1;
            end else begin
                in_valid[0] = 1'b0;
            end
            @(posedge clk); #1;
            vectors++;
            if (out_valid[0] !== 1'b1 || out_state[0] !== exp || in_ready[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold[c%0d]: got v=%b r=%b %h, want v=1 r=0 %h",
                         c, out_valid[0], in_ready[0], out_state[0], exp);
            end
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        vectors++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release: got v=%b r=%b, want v=0 r=1", out_valid[0], in_ready[0]);
        end
        bad = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) bad = 1'b1;
        end
        vectors++;
        if (bad !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_no_capture: got activity=%b, want 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] res;
        int           lat;
        logic         seen;
        in_state[0] = fill(8'h00);
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_async: got v=%b b=%b, want v=0 b=0", out_valid[0], busy[0]);
        end
        vectors++;
        if (out_state[0] !== 128'h0 || in_ready[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_values: got r=%b %h, want r=1 0", in_ready[0], out_state[0]);
        end
        #2;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid[0] !== 1'b0) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_no_output: got seen=%b, want 0", seen);
        end
        run_state(0, fill(8'h52), res, lat);
        vectors++;
        if (res !== fill(8'h48)) begin
            miscompares++;
            $display("FAIL midrst_after_52: got %h, want %h", res, fill(8'h48));
        end
        vectors++;
        if (lat !== 4) begin
            miscompares++;
            $display("FAIL midrst_latency: got %0d, want 4", lat);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            in_valid[k]  = 1'b0;
            in_state[k]  = '0;
            out_ready[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        test_reset();
        test_single_values();
        test_table(0);
        test_back_pressure();
        test_reset_mid();
        for (int k = 1; k < NDUT; k++) begin
            test_table(k);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit, miscompares so far %0d", miscompares);
        $fatal(1);
    end

endmodule
